// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Contents: opcode constants, datapath mux codes, the controller state
// enum, the registered control-word struct, and the pure functions that
// give the next state and the control word for each state.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT       = 2'd0;
    localparam logic [1:0] SRCB_FOUR     = 2'd1;
    localparam logic [1:0] SRCB_SEXT     = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       addi;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

    function automatic logic is_defined_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HLT: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic ready);
        state_t n;
        case (s)
            S_IDLE:   n = S_FETCH;
            S_FETCH:  n = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = S_EXEC;
                    OP_BEQ:       n = S_BRANCH;
                    OP_J:         n = S_JUMP;
                    OP_ADDI:      n = S_ADDIEX;
                    OP_HLT:       n = S_HALT;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  n = S_FETCH;
            S_MEMWR:  n = ready ? S_FETCH : S_MEMWR;
            S_EXEC:   n = S_RWB;
            S_RWB:    n = S_FETCH;
            S_ADDIEX: n = S_ADDIWB;
            S_ADDIWB: n = S_FETCH;
            S_BRANCH: n = S_FETCH;
            S_JUMP:   n = S_FETCH;
            S_HALT:   n = S_HALT;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    // Control word held while in state s. Fields not listed stay 0.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRCB_SEXT_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
                c.addi      = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
// Ports: clk, rst (async active-low, clears count), en (count this cycle),
//        count (current value).
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle MIPS datapath sharing one memory for
// instruction fetch and data access.
// Ports: clk, rst (async active-low); opcode (IR[31:26]), zero (ALU flag),
//        mem_ready (memory handshake); datapath controls MemRead, MemWrite,
//        mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA,
//        ALUSrcB, ALUOp, addi, RegDst, MemtoReg, RegWrite; status halted,
//        illegal, retire; counters cycle_cnt, instr_cnt.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             addi,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             halted,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;

    assign state_next = next_state(state_reg, opcode, mem_ready);

    // The control word is registered alongside the state, so it always
    // equals the decode of the current state without a combinational path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_of(state_next);
        end
    end

    logic in_decode;
    logic in_fetch;
    logic count_en;

    assign in_decode = (state_reg == S_DECODE);
    // Only FETCH raises IRWrite in its control word.
    assign in_fetch  = ctrl_reg.ir_write;

    assign MemRead     = ctrl_reg.mem_read;
    assign MemWrite    = ctrl_reg.mem_write;
    assign mem_req     = ctrl_reg.mem_read | ctrl_reg.mem_write;
    assign IorD        = ctrl_reg.iord;
    assign PCWriteCond = ctrl_reg.pc_write_cond;
    assign PCSource    = ctrl_reg.pc_source;
    assign ALUSrcA     = ctrl_reg.alu_src_a;
    assign ALUSrcB     = ctrl_reg.alu_src_b;
    assign ALUOp       = ctrl_reg.alu_op;
    assign addi        = ctrl_reg.addi;
    assign RegDst      = ctrl_reg.reg_dst;
    assign MemtoReg    = ctrl_reg.mem_to_reg;
    assign RegWrite    = ctrl_reg.reg_write;
    assign halted      = ctrl_reg.halted;

    // PC and IR update in FETCH only on the cycle the memory delivers.
    assign IRWrite = ctrl_reg.ir_write & mem_ready;
    assign PCWrite = (ctrl_reg.pc_write & (~in_fetch | mem_ready))
                   | (ctrl_reg.pc_write_cond & zero);

    assign illegal = in_decode & ~is_defined_op(opcode);

    // An instruction completes when leaving its final state; HLT completes
    // in DECODE as it enters HALT, and a store only once the write lands.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR:  retire = mem_ready;
            S_DECODE: retire = (opcode == OP_HLT);
            default:  retire = 1'b0;
        endcase
    end

    assign count_en = (state_reg != S_IDLE) && (state_reg != S_HALT);

    perf_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en),
        .count (cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_instr_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (instr_cnt)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [5:0] T_RTYPE = 6'h00;
    localparam logic [5:0] T_LW    = 6'h23;
    localparam logic [5:0] T_SW    = 6'h2B;
    localparam logic [5:0] T_BEQ   = 6'h04;
    localparam logic [5:0] T_J     = 6'h02;
    localparam logic [5:0] T_ADDI  = 6'h08;
    localparam logic [5:0] T_HLT   = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic        ALUSrcA, addi, RegDst, MemtoReg, RegWrite, halted, illegal, retire;
    logic [31:0] cycle_cnt, instr_cnt;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .addi(addi), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .halted(halted), .illegal(illegal), .retire(retire),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction is a queue of phases; a phase either lasts one cycle
    // or waits for mem_ready. The tail after DECODE depends on the opcode.
    typedef struct packed {
        logic       rd, wr, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic       ad, rdst, m2r, rw;
    } ctl_t;

    typedef struct packed {
        ctl_t c;
        logic waits, fetch, last, dec;
    } ph_t;

    function automatic ph_t phase_of(input string n);
        ph_t p;
        p = '0;
        case (n)
            "FETCH":  begin p.c.rd = 1; p.c.irw = 1; p.c.sb = 2'd1; p.c.pcw = 1;
                            p.waits = 1; p.fetch = 1; end
            "DECODE": begin p.c.sb = 2'd3; p.dec = 1; end
            "MEMADR": begin p.c.sa = 1; p.c.sb = 2'd2; end
            "MEMRD":  begin p.c.rd = 1; p.c.iord = 1; p.waits = 1; end
            "MEMWB":  begin p.c.rw = 1; p.c.m2r = 1; p.last = 1; end
            "MEMWR":  begin p.c.wr = 1; p.c.iord = 1; p.waits = 1; p.last = 1; end
            "EXEC":   begin p.c.sa = 1; p.c.aop = 2'b10; end
            "RWB":    begin p.c.rw = 1; p.c.rdst = 1; p.last = 1; end
            "ADDIEX": begin p.c.sa = 1; p.c.sb = 2'd2; p.c.ad = 1; end
            "ADDIWB": begin p.c.rw = 1; p.last = 1; end
            "BRANCH": begin p.c.sa = 1; p.c.aop = 2'b01; p.c.pcwc = 1; p.c.pcsrc = 2'd1;
                            p.last = 1; end
            "JUMP":   begin p.c.pcw = 1; p.c.pcsrc = 2'd2; p.last = 1; end
            default:  p = '0;
        endcase
        return p;
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return (op == T_RTYPE) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) ||
               (op == T_J) || (op == T_ADDI) || (op == T_HLT);
    endfunction

    ph_t         q[$];
    bit          m_idle = 1'b1;
    bit          m_halt = 1'b0;
    logic [5:0]  dec_op = 6'h00;
    logic [31:0] cyc_m = 0;
    logic [31:0] ins_m = 0;
    bit          act_prev = 1'b0;
    bit          ret_prev = 1'b0;

    task automatic model_reset();
        q.delete();
        m_idle = 1'b1; m_halt = 1'b0;
        cyc_m = 0; ins_m = 0; act_prev = 1'b0; ret_prev = 1'b0;
    endtask

    task automatic start_instr();
        q.push_back(phase_of("FETCH"));
        q.push_back(phase_of("DECODE"));
    endtask

    task automatic append_tail(input logic [5:0] op);
        case (op)
            T_LW:    begin q.push_back(phase_of("MEMADR")); q.push_back(phase_of("MEMRD"));
                           q.push_back(phase_of("MEMWB")); end
            T_SW:    begin q.push_back(phase_of("MEMADR")); q.push_back(phase_of("MEMWR")); end
            T_RTYPE: begin q.push_back(phase_of("EXEC")); q.push_back(phase_of("RWB")); end
            T_BEQ:   q.push_back(phase_of("BRANCH"));
            T_J:     q.push_back(phase_of("JUMP"));
            T_ADDI:  begin q.push_back(phase_of("ADDIEX")); q.push_back(phase_of("ADDIWB")); end
            T_HLT:   m_halt = 1'b1;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin : model_check
        ph_t         head;
        ctl_t        x;
        bit          hl, ill, ret;
        logic [20:0] exp_v, act_v;
        // advance on the edge using the inputs of the cycle just ended
        if (!rst) begin
            model_reset();
        end else begin
            if (act_prev) cyc_m = cyc_m + 1;
            if (ret_prev) ins_m = ins_m + 1;
            if (m_idle) begin
                m_idle = 1'b0;
                start_instr();
            end else if (!m_halt && q.size() > 0) begin
                head = q[0];
                if (!head.waits || mem_ready) begin
                    void'(q.pop_front());
                    if (head.dec) append_tail(dec_op);
                    if (q.size() == 0 && !m_halt) start_instr();
                end
            end
        end
        #2;
        if (!rst) model_reset();
        x = '0; hl = 1'b0; ill = 1'b0; ret = 1'b0;
        act_prev = 1'b0;
        if (rst && !m_idle) begin
            if (m_halt) begin
                hl = 1'b1;
            end else begin
                head = q[0];
                x = head.c;
                act_prev = 1'b1;
                if (head.fetch) begin
                    x.irw = mem_ready;
                    x.pcw = mem_ready;
                end
                if (x.pcwc && zero) x.pcw = 1'b1;
                if (head.dec) begin
                    dec_op = opcode;
                    ill = !known_op(opcode);
                    ret = (opcode == T_HLT);
                end else begin
                    ret = head.last && (!head.waits || mem_ready);
                end
            end
        end
        ret_prev = ret;
        exp_v = {x, x.rd | x.wr, hl, ill, ret};
        act_v = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                 ALUSrcA, ALUSrcB, ALUOp, addi, RegDst, MemtoReg, RegWrite,
                 mem_req, halted, illegal, retire};
        chk("model_ctl", 64'(act_v), 64'(exp_v));
        chk("model_cycle_cnt", 64'(cycle_cnt), 64'(cyc_m));
        chk("model_instr_cnt", 64'(instr_cnt), 64'(ins_m));
    end

    // ---------------- stimulus ----------------
    // One cycle: drive inputs 1 time unit after the edge, return at +3.
    task automatic step(input bit mr, input bit z, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr; zero = z; opcode = op;
        #2;
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        logic [5:0] bad [4];
        bad[0] = 6'h11; bad[1] = 6'h01; bad[2] = 6'h3E; bad[3] = 6'h2A;
        r = int'($urandom_range(0, 39));
        if (r == 0)       return T_HLT;
        else if (r <= 3)  return bad[$urandom_range(0, 3)];
        else if (r <= 11) return T_RTYPE;
        else if (r <= 17) return T_LW;
        else if (r <= 23) return T_SW;
        else if (r <= 29) return T_BEQ;
        else if (r <= 33) return T_J;
        else              return T_ADDI;
    endfunction

    initial begin : stim
        bit lw_mr [11];
        int irw_n;
        int halt_cycles;
        bit irw_seen;
        logic [5:0] cur_op;
        lw_mr = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};

        // reset held with clock running
        #1 rst = 1'b0;
        repeat (3) step(1, 0, T_RTYPE);
        chk("reset_outputs", 64'({MemRead, MemWrite, mem_req, IRWrite, PCWrite, RegWrite,
                                  halted, illegal, retire, ALUSrcB, PCSource}), 64'd0);
        chk("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);

        // release -> FETCH next cycle; R-type with mem_ready tied high
        @(posedge clk); #1 rst = 1'b1;
        step(1, 0, T_RTYPE);
        chk("fetch_memread", 64'(MemRead), 64'd1);
        chk("fetch_irwrite", 64'(IRWrite), 64'd1);
        step(1, 0, T_RTYPE);
        chk("decode_alusrcb", 64'(ALUSrcB), 64'd3);
        step(1, 0, T_RTYPE);
        chk("exec_regwrite", 64'({RegWrite, ALUOp}), 64'b010);
        step(1, 0, T_RTYPE);
        chk("rwb_regwrite_regdst", 64'({RegWrite, RegDst}), 64'b11);

        // lw with 3 stall cycles in FETCH and in MEMRD: 11 cycles
        irw_n = 0;
        for (int i = 0; i < 11; i++) begin
            step(lw_mr[i], 0, T_LW);
            if (i == 0) begin
                chk("rtype_instr_cnt", 64'(instr_cnt), 64'd1);
                chk("rtype_cycle_cnt", 64'(cycle_cnt), 64'd4);
            end
            if (IRWrite) irw_n++;
            if (i == 10) chk("lw_memwb", 64'({MemtoReg, RegWrite, RegDst, retire}), 64'b1101);
        end
        chk("lw_irwrite_once", 64'(irw_n), 64'd1);

        // beq taken then not taken
        step(1, 0, T_BEQ);
        chk("lw_instr_cnt", 64'(instr_cnt), 64'd2);
        chk("lw_cycle_cnt", 64'(cycle_cnt), 64'd15);
        step(1, 0, T_BEQ);
        step(1, 1, T_BEQ);
        chk("beq_taken", 64'({PCWrite, PCSource, retire}), 64'b1011);
        step(1, 0, T_BEQ);
        step(1, 0, T_BEQ);
        step(1, 0, T_BEQ);
        chk("beq_not_taken", 64'({PCWrite, PCSource, retire}), 64'b0011);

        // undefined opcode
        step(1, 0, 6'h11);
        chk("beq_instr_cnt", 64'(instr_cnt), 64'd4);
        step(1, 0, 6'h11);
        chk("illegal_pulse", 64'({illegal, retire}), 64'b10);
        step(1, 0, T_RTYPE);
        chk("illegal_back_fetch", 64'({illegal, MemRead}), 64'b01);
        chk("illegal_instr_cnt", 64'(instr_cnt), 64'd4);

        // randomized run; the opcode changes only once a new IR is loaded
        halt_cycles = 0;
        irw_seen = 1'b0;
        cur_op = T_RTYPE;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (irw_seen) cur_op = rand_op();
            rst = !((halt_cycles >= 3) || ($urandom_range(0, 299) == 0));
            mem_ready = ($urandom_range(0, 99) < 65);
            zero = 1'($urandom_range(0, 1));
            opcode = cur_op;
            #2;
            irw_seen = IRWrite;
            halt_cycles = halted ? halt_cycles + 1 : 0;
        end

        // reset during a stalled store
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        step(1, 0, T_SW);
        step(1, 0, T_SW);
        step(1, 0, T_SW);
        step(0, 0, T_SW);
        chk("memwr_stall", 64'({MemWrite, mem_req, IorD, retire}), 64'b1110);
        #2 rst = 1'b0;
        #1;
        chk("memwr_async_reset", 64'({MemWrite, mem_req, IorD}), 64'd0);
        chk("memwr_reset_counts", 64'({cycle_cnt, instr_cnt}), 64'd0);

        // halt
        @(posedge clk); #1 rst = 1'b1;
        step(1, 0, T_HLT);
        step(1, 0, T_HLT);
        chk("hlt_retire", 64'(retire), 64'd1);
        repeat (5) step(1, 0, T_HLT);
        chk("halted", 64'({halted, MemRead, retire}), 64'b100);
        chk("halt_cycle_frozen", 64'(cycle_cnt), 64'd2);
        chk("halt_instr_cnt", 64'(instr_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
